spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SPI master engine among NUM_REQ on-chip requesters. It grants one requester at a time and issues the send_data launch pulse with that requester's byte. It waits for the engine's receive_data completion, then returns the received byte with a per-requester done pulse. It sits between the APB-side requester logic and the SPI engine (baud generator, slave-select and shift register).

---
 rtl/spi_xfer_arbiter_if.sv | 50 +++++
 rtl/spi_xfer_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_arbiter_if
//  Description : Bundles the requester-side and SPI-engine-side signals of
//                the SPI transfer arbiter.
//                master : arbiter view (drives grants, launch, results)
//                slave  : environment view (requesters plus SPI engine)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_xfer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  // Mode and requester side
  logic                      mstr_i;
  logic                      spiswai_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] tx_data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic [DATA_W-1:0]         rx_data_o;
  logic                      busy_o;
  logic                      err_o;

  // SPI engine side
  logic                      send_data_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tip_i;
  logic                      receive_data_i;
  logic [DATA_W-1:0]         rx_data_i;

  // Arbiter side
  modport master (
    input  mstr_i, spiswai_i, req_i, tx_data_i,
    input  tip_i, receive_data_i, rx_data_i,
    output gnt_o, done_o, rx_data_o, busy_o, err_o,
    output send_data_o, tx_data_o
  );

  // Requesters and SPI engine side
  modport slave (
    output mstr_i, spiswai_i, req_i, tx_data_i,
    output tip_i, receive_data_i, rx_data_i,
    input  gnt_o, done_o, rx_data_o, busy_o, err_o,
    input  send_data_o, tx_data_o
  );

endinterface : spi_xfer_arbiter_if
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_arbiter
//  Description : Round-robin arbiter/sequencer sharing one SPI master engine
//                among NUM_REQ requesters. Grants one requester, launches its
//                byte with send_data_o, waits for receive_data_i and returns
//                the received byte with a one-cycle done pulse.
//                Optional macro SPI_ARB_TIMEOUT_EN adds a WAIT_RX timeout
//                that completes the transfer with err_o after TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input wire                 PCLK,
  input wire                 PRESET_n,
  spi_xfer_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [NUM_REQ-1:0] gnt, gnt_nxt;
  logic [NUM_REQ-1:0] done, done_nxt;
  logic [DATA_W-1:0]  rx_q, rx_nxt;
  logic [DATA_W-1:0]  tx_q, tx_nxt;
  logic               send, send_nxt;
  logic               busy;

  // --------------------------------------------------------------------------
  // Round-robin winner selection. Requests strictly above the pointer win
  // first (lowest index among them); otherwise wrap to the lowest request.
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] above_ptr;
  logic [NUM_REQ-1:0] req_hi;
  logic [IDX_W-1:0]   win;
  logic               grant_ok;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (v[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Mask of requester positions that follow the pointer without wrapping
  always_comb begin
    above_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      above_ptr[k] = (k > int'(ptr));
    end
  end

  assign req_hi   = bus.req_i & above_ptr;
  assign win      = (|req_hi) ? lowest_set(req_hi) : lowest_set(bus.req_i);
  assign grant_ok = bus.mstr_i & ~bus.spiswai_i & ~bus.tip_i & (|bus.req_i);

  // --------------------------------------------------------------------------
  // Optional WAIT_RX timeout
  // --------------------------------------------------------------------------
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             err, err_nxt;

  // Last WAIT_RX cycle of the allowed window: the count reaches
  // TIMEOUT_CYCLES at the edge that leaves WAIT_RX.
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

  // Count WAIT_RX cycles; cleared while in LAUNCH so it starts at zero
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      wait_cnt <= '0;
    end else if (state == ST_LAUNCH) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT_RX) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Registered timeout pulse
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end

  assign bus.err_o = err;
`else
  assign bus.err_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic; every output is registered below so
  // the values computed here appear one cycle later.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    send_nxt  = 1'b0;
    rx_nxt    = rx_q;
    tx_nxt    = tx_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_nxt   = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        gnt_nxt = '0;
        if (grant_ok) begin
          state_nxt = ST_LAUNCH;
          idx_nxt   = win;
          gnt_nxt   = onehot(win);
          send_nxt  = 1'b1;
          tx_nxt    = bus.tx_data_i[int'(win)*DATA_W +: DATA_W];
        end
      end

      ST_LAUNCH: begin
        // Leaving master mode abandons the transfer without a done pulse
        if (!bus.mstr_i) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end else begin
          state_nxt = ST_WAIT_RX;
        end
      end

      ST_WAIT_RX: begin
        if (!bus.mstr_i) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end else if (bus.receive_data_i) begin
          state_nxt = ST_DONE;
          done_nxt  = onehot(idx);
          rx_nxt    = bus.rx_data_i;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          // Completes with an error flag; the last received byte is kept
          state_nxt = ST_DONE;
          done_nxt  = onehot(idx);
          err_nxt   = 1'b1;
        end
`endif
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        ptr_nxt   = idx;
      end

      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and arbitration bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      ptr  <= PTR_RESET;
      idx  <= '0;
      gnt  <= '0;
      done <= '0;
      send <= 1'b0;
      busy <= 1'b0;
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      ptr  <= ptr_nxt;
      idx  <= idx_nxt;
      gnt  <= gnt_nxt;
      done <= done_nxt;
      send <= send_nxt;
      busy <= (state_nxt != ST_IDLE);
      rx_q <= rx_nxt;
      tx_q <= tx_nxt;
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.done_o      = done;
  assign bus.rx_data_o   = rx_q;
  assign bus.busy_o      = busy;
  assign bus.send_data_o = send;
  assign bus.tx_data_o   = tx_q;

endmodule : spi_xfer_arbiter
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_xfer_arbiter
//  Description : Self-checking bench for spi_xfer_arbiter. A transaction-level
//                model tracks the round-robin pointer and the last received
//                byte; randomized masks, data and engine latencies drive it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TXW            = NUM_REQ * DATA_W;

  logic PCLK = 1'b0;
  logic PRESET_n;

  spi_xfer_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  spi_xfer_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .PCLK     (PCLK),
    .PRESET_n (PRESET_n),
    .bus      (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int                ptr;
  logic [DATA_W-1:0] exp_rx;
  logic [DATA_W-1:0] cur_tx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requester found walking upward from the pointer, modulo NUM_REQ
  function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] m);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic at_sample();
    @(negedge PCLK);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
  endtask

  // Called inside an IDLE cycle before its sampling edge; returns at the
  // sample point of the LAUNCH cycle.
  task automatic launch(input logic [NUM_REQ-1:0] mask, input logic [TXW-1:0] txv,
                        output int w);
    w = rr_pick(ptr, mask);
    cur_tx = txv[w*DATA_W +: DATA_W];
    bus.req_i     = mask;
    bus.tx_data_i = txv;
    next_cycle();
    // A stray completion outside WAIT_RX must be ignored
    bus.receive_data_i = ($urandom_range(0, 1) == 1);
    bus.rx_data_i      = DATA_W'($urandom);
    at_sample();
    chk("gnt_launch",  32'(bus.gnt_o), 32'(1) << w);
    chk("send_launch", 32'(bus.send_data_o), 32'd1);
    chk("tx_launch",   32'(bus.tx_data_o), 32'(cur_tx));
    chk("busy_launch", 32'(bus.busy_o), 32'd1);
  endtask

  // Engine answers d cycles after LAUNCH; ends at the sample point of the
  // IDLE cycle that follows DONE, with req_i restored to mask.
  task automatic complete(input int w, input int d, input logic [NUM_REQ-1:0] mask,
                          input logic [DATA_W-1:0] r);
    for (int c = 1; c < d; c++) begin
      next_cycle();
      bus.receive_data_i = 1'b0;
      bus.tip_i          = 1'b1;
      bus.req_i          = NUM_REQ'($urandom);
      bus.tx_data_i      = TXW'($urandom);
      bus.spiswai_i      = ($urandom_range(0, 3) == 0);
      at_sample();
      chk("gnt_wait",  32'(bus.gnt_o), 32'(1) << w);
      chk("done_wait", 32'(bus.done_o), 32'd0);
    end
    next_cycle();
    bus.receive_data_i = 1'b1;
    bus.rx_data_i      = r;
    bus.tip_i          = 1'b0;
    at_sample();
    chk("send_wait", 32'(bus.send_data_o), 32'd0);
    chk("gnt_rx",    32'(bus.gnt_o), 32'(1) << w);
    next_cycle();
    bus.receive_data_i = 1'b0;
    bus.rx_data_i      = DATA_W'($urandom);
    bus.req_i          = mask;
    bus.spiswai_i      = 1'b0;
    at_sample();
    ptr    = w;
    exp_rx = r;
    chk("done_pulse", 32'(bus.done_o), 32'(1) << w);
    chk("rx_data",    32'(bus.rx_data_o), 32'(exp_rx));
    chk("gnt_done",   32'(bus.gnt_o), 32'(1) << w);
    chk("tx_held",    32'(bus.tx_data_o), 32'(cur_tx));
    chk("err_done",   32'(bus.err_o), 32'd0);
    next_cycle();
    at_sample();
    chk_idle("after_done");
    chk("rx_kept", 32'(bus.rx_data_o), 32'(exp_rx));
  endtask

  // Drop mstr_i at the current sample point (LAUNCH or WAIT_RX); returns in
  // the following IDLE cycle with mstr_i high again and req_i cleared.
  task automatic abort_xfer();
    bus.mstr_i = 1'b0;
    next_cycle();
    bus.receive_data_i = 1'b0;
    bus.tip_i          = 1'b0;
    at_sample();
    chk_idle("abort");
    chk("abort_send", 32'(bus.send_data_o), 32'd0);
    chk("abort_rx",   32'(bus.rx_data_o), 32'(exp_rx));
    bus.req_i  = '0;
    bus.mstr_i = 1'b1;
  endtask

  task automatic enter_wait(input int w);
    next_cycle();
    bus.receive_data_i = 1'b0;
    bus.tip_i          = 1'b1;
    at_sample();
    chk("gnt_wait1", 32'(bus.gnt_o), 32'(1) << w);
    chk("send_low",  32'(bus.send_data_o), 32'd0);
  endtask

  function automatic logic [NUM_REQ-1:0] rand_mask();
    logic [NUM_REQ-1:0] m;
    m = NUM_REQ'($urandom);
    if (m == '0) m = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
    return m;
  endfunction

  initial begin
    int w;
    int mode;
    logic [TXW-1:0] txv;

    PRESET_n           = 1'b0;
    bus.mstr_i         = 1'b0;
    bus.spiswai_i      = 1'b0;
    bus.req_i          = '0;
    bus.tx_data_i      = '0;
    bus.tip_i          = 1'b0;
    bus.receive_data_i = 1'b0;
    bus.rx_data_i      = '0;
    ptr    = NUM_REQ - 1;
    exp_rx = '0;

    // Reset state
    repeat (3) next_cycle();
    at_sample();
    chk_idle("reset");
    chk("reset_send", 32'(bus.send_data_o), 32'd0);
    chk("reset_err",  32'(bus.err_o), 32'd0);
    chk("reset_rx",   32'(bus.rx_data_o), 32'd0);
    chk("reset_tx",   32'(bus.tx_data_o), 32'd0);
    next_cycle();
    PRESET_n   = 1'b1;
    bus.mstr_i = 1'b1;
    next_cycle();

    // Basic transfer: requester 0 sends A5, engine returns 3C
    txv = TXW'($urandom);
    txv[DATA_W-1:0] = 8'hA5;
    launch(4'b0001, txv, w);
    complete(w, 5, 4'b0001, 8'h3C);
    bus.req_i = '0;

    // Reset in the middle of a transfer
    launch(4'b0010, TXW'($urandom), w);
    enter_wait(w);
    bus.req_i = '0;
    #2 PRESET_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_rx", 32'(bus.rx_data_o), 32'd0);
    chk("async_rst_tx", 32'(bus.tx_data_o), 32'd0);
    bus.tip_i = 1'b0;
    ptr    = NUM_REQ - 1;
    exp_rx = '0;
    next_cycle();
    PRESET_n = 1'b1;
    next_cycle();

    // All requesting: rotation 0,1,2,3,0 back to back
    for (int i = 0; i < 5; i++) begin
      launch(4'b1111, TXW'($urandom), w);
      complete(w, $urandom_range(1, 6), 4'b1111, DATA_W'($urandom));
    end

    // Wait mode holds off new grants
    bus.req_i     = 4'b0001;
    bus.spiswai_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      at_sample();
      chk_idle("spiswai_block");
    end
    bus.spiswai_i = 1'b0;
    launch(4'b0001, TXW'($urandom), w);
    complete(w, 3, 4'b0001, DATA_W'($urandom));

    // Engine busy holds off new grants
    bus.tip_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      at_sample();
      chk_idle("tip_block");
    end
    bus.tip_i = 1'b0;
    launch(4'b0001, TXW'($urandom), w);
    complete(w, 2, 4'b0001, DATA_W'($urandom));

    // Abort keeps the pointer: serve 1, abort 2, then 0101 picks 2 again
    launch(4'b0010, TXW'($urandom), w);
    complete(w, 2, 4'b0010, DATA_W'($urandom));
    launch(4'b0100, TXW'($urandom), w);
    enter_wait(w);
    abort_xfer();
    launch(4'b0101, TXW'($urandom), w);
    chk("abort_reselect", 32'(bus.gnt_o), 32'b0100);
    complete(w, 4, 4'b0101, DATA_W'($urandom));

    // Randomized traffic with occasional aborts and idle gaps
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 7);
      launch(rand_mask(), TXW'($urandom), w);
      if (mode == 0) begin
        abort_xfer();
      end else if (mode == 1) begin
        enter_wait(w);
        abort_xfer();
      end else begin
        complete(w, $urandom_range(1, 8), bus.req_i, DATA_W'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.req_i = '0;
        repeat ($urandom_range(1, 3)) begin
          next_cycle();
          at_sample();
          chk_idle("gap");
        end
      end
    end

    // Engine never answers
    bus.req_i = '0;
    launch(4'b1000, TXW'($urandom), w);
`ifdef SPI_ARB_TIMEOUT_EN
    for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
      next_cycle();
      bus.receive_data_i = 1'b0;
      bus.tip_i          = 1'b1;
      bus.req_i          = '0;
      at_sample();
      chk("to_wait_done", 32'(bus.done_o), 32'd0);
      chk("to_wait_err",  32'(bus.err_o), 32'd0);
    end
    next_cycle();
    bus.tip_i = 1'b0;
    at_sample();
    ptr = w;
    chk("to_done", 32'(bus.done_o), 32'(1) << w);
    chk("to_err",  32'(bus.err_o), 32'd1);
    chk("to_rx",   32'(bus.rx_data_o), 32'(exp_rx));
    next_cycle();
    at_sample();
    chk_idle("to_after");
    chk("to_err_low", 32'(bus.err_o), 32'd0);
    launch(4'b1001, TXW'($urandom), w);
    chk("to_ptr_adv", 32'(bus.gnt_o), 32'b0001);
    complete(w, 2, 4'b0000, DATA_W'($urandom));
`else
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      bus.receive_data_i = 1'b0;
      bus.tip_i          = 1'b1;
      bus.req_i          = '0;
      at_sample();
      chk("hang_busy", 32'(bus.busy_o), 32'd1);
      chk("hang_err",  32'(bus.err_o), 32'd0);
      chk("hang_gnt",  32'(bus.gnt_o), 32'(1) << w);
    end
    abort_xfer();
`endif
    bus.req_i = '0;
    next_cycle();
    at_sample();
    chk_idle("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit reached");
  end

endmodule : tb_spi_xfer_arbiter
`default_nettype wire
